fault_event_tracker: RTL
========================

// Module: fault_event_tracker
// PURPOSE
//  Upstream stage of the LED driver. Converts raw bot events into clean, held status levels for it.
//  Raw events come from the path planner, line follower, IR fault sensor and arm controller.
//  Debounces the IR fault sensor and tracks one fault-service cycle: detect -> pick -> drop.
//  Tags each fault with the unit it occurred in (EU/CU/RU) and stretches short pulses.
//  Produces fault_detect, block_picked, object_drop, node_flag, run_complete and the
//  EU/CU/RU fault flags.
// PARAMETERS
//  DEBOUNCE_CYC  3125    clk cycles fault_raw must stay high to count as a fault (1 ms)
//  PULSE_HOLD    312500  clk cycles node_flag / object_drop are held high (100 ms)
// PORTS
//  clk_3125KHz     in   1  system clock, 3.125 MHz; sole clock domain
//  rst_n           in   1  reset, synchronous, active-low
//  fault_raw       in   1  asynchronous IR fault sensor level
//  unit_sel        in   2  current unit: 00=EU, 01=CU, 10=RU, 11=none/transit
//  node_reached    in   1  1-cycle pulse, bot arrived at a node
//  pick_done       in   1  1-cycle pulse, arm finished picking the fault block
//  drop_done       in   1  1-cycle pulse, arm finished dropping the block
//  run_end         in   1  1-cycle pulse, planner finished the run
//  fault_detect    out  1  high while a fault is awaiting pickup
//  block_picked    out  1  high while the block is carried
//  object_drop     out  1  high for PULSE_HOLD cycles after a drop
//  node_flag       out  1  high for PULSE_HOLD cycles after node_reached
//  run_complete    out  1  sticky; high from run_end until reset
//  EU_fault_flag   out  1  high while the active fault belongs to EU
//  CU_fault_flag   out  1  high while the active fault belongs to CU
//  RU_fault_flag   out  1  high while the active fault belongs to RU
//  fault_count     out  2  faults serviced (drop completed), saturates at 3
// BEHAVIOUR
//  Reset: all outputs 0. FSM in S_IDLE. All counters 0. Synchronizer and debouncer cleared.
//  Sync/debounce:
//   - fault_raw passes a 2-FF synchronizer.
//   - Debounced level rises after DEBOUNCE_CYC consecutive synced highs.
//   - Any low clears the count and the level.
//   - Only the debounced rising edge (fault_evt) is an event; a held level never retriggers.
//  FSM, all outputs registered:
//   - S_IDLE:
//     - fault_evt with unit_sel != 11: latch unit_q <= unit_sel, go to S_FAULT.
//     - fault_evt with unit_sel == 11: dropped silently.
//   - S_FAULT: fault_detect=1. pick_done -> S_CARRY.
//   - S_CARRY: block_picked=1. drop_done -> S_DROP. fault_count += 1 (saturating).
//   - S_DROP: object_drop=1 for exactly PULSE_HOLD cycles, then S_IDLE.
//  Unit flags: one-hot decode of unit_q. High in S_FAULT, S_CARRY and S_DROP; 0 in S_IDLE.
//   unit_q holds even if unit_sel changes.
//  fault_evt outside S_IDLE: ignored, with no queueing.
//  pick_done and drop_done in the same cycle while in S_FAULT: only pick is taken.
//  drop_done in S_FAULT or pick_done in S_CARRY: ignored.
//  run_end, any state:
//   - run_complete=1 next cycle; FSM forced to S_IDLE.
//   - fault_detect, block_picked, object_drop and unit flags clear the same edge.
//   - All later fault/pick/drop events are ignored until reset. node_flag keeps operating.
//  node_flag: node_reached loads the hold counter with PULSE_HOLD.
//   - Output is high while the count is nonzero.
//   - A retrigger while high reloads the counter, so there is no gap.
//  Event-to-output latency: 1 cycle for FSM events. Sensor path: 2 (sync) + DEBOUNCE_CYC + 1.
//  Counters are 32-bit, compared against parameters. No wrap is possible.
//  rst_n low mid-operation: everything returns to reset values on that edge.
// STRUCTURE
//  Shared package astro_pkg:
//   - FSM state localparams: S_IDLE, S_FAULT, S_CARRY, S_DROP.
//   - Unit codes: UNIT_EU, UNIT_CU, UNIT_RU, UNIT_NONE.
//  Sub-module fault_debouncer (sync + DEBOUNCE_CYC counter; outputs level and fault_evt).
//  Pulse stretchers and FSM are inline.
// TESTING (bench overrides DEBOUNCE_CYC=4, PULSE_HOLD=8)
//  1. Reset, then fault_raw high 10 cycles with unit_sel=01:
//     fault_detect=1 and CU_fault_flag=1 at cycle 2+4+1.
//     A 3-cycle glitch gives no response.
//  2. Fault, then pick_done, then drop_done:
//     block_picked=1 then object_drop=1 for exactly 8 cycles.
//     Then CU_fault_flag=0 and fault_count=1.
//  3. fault_raw high with unit_sel=11: no output change.
//     A second fault during S_CARRY is ignored; count stays 1.
//  4. node_reached at t=0 and t=5: node_flag high continuously from t=1 to t=13.
//  5. run_end during S_CARRY: next cycle block_picked=0, EU/CU/RU flags 0, run_complete=1.
//     Later faults are ignored.
//  6. rst_n low mid-S_DROP: all outputs 0 on that edge, fault_count=0.

Source files
------------

// File: rtl/astro_pkg.sv
// Shared types and constants for the fault event tracker: FSM state encoding and unit codes.
package astro_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FAULT = 2'b01,
      S_CARRY = 2'b10,
      S_DROP  = 2'b11
   } state_t;

   localparam logic [1:0] UNIT_EU   = 2'b00;
   localparam logic [1:0] UNIT_CU   = 2'b01;
   localparam logic [1:0] UNIT_RU   = 2'b10;
   localparam logic [1:0] UNIT_NONE = 2'b11;

   localparam logic [1:0] FAULT_COUNT_MAX = 2'd3;

endpackage

// File: rtl/fault_event_tracker_if.sv
// Bundle of bot event inputs and held status outputs exchanged with the fault event tracker.
interface fault_event_tracker_if;
   import astro_pkg::*;

   // No backpressure: every event is a one-cycle strobe (valid only, ready is implicitly 1),
   // sampled on each clock edge; status outputs are levels valid whenever observed.
   logic       fault_raw;
   logic [1:0] unit_sel;
   logic       node_reached;
   logic       pick_done;
   logic       drop_done;
   logic       run_end;

   logic       fault_detect;
   logic       block_picked;
   logic       object_drop;
   logic       node_flag;
   logic       run_complete;
   logic       EU_fault_flag;
   logic       CU_fault_flag;
   logic       RU_fault_flag;
   logic [1:0] fault_count;

   state_t     fsm_state;
   logic       fault_level;

   modport master (
      output fault_raw, unit_sel, node_reached, pick_done, drop_done, run_end,
      input  fault_detect, block_picked, object_drop, node_flag, run_complete,
      input  EU_fault_flag, CU_fault_flag, RU_fault_flag, fault_count,
      input  fsm_state, fault_level
   );

   modport slave (
      input  fault_raw, unit_sel, node_reached, pick_done, drop_done, run_end,
      output fault_detect, block_picked, object_drop, node_flag, run_complete,
      output EU_fault_flag, CU_fault_flag, RU_fault_flag, fault_count,
      output fsm_state, fault_level
   );

endinterface

// File: rtl/fault_debouncer.sv
// Two-flop synchronizer plus consecutive-high counter for the IR fault sensor.
// fault_evt is a single-cycle strobe on the debounced rising edge only.
module fault_debouncer #(
   parameter int unsigned DEBOUNCE_CYC = 3125
) (
   input  logic clk,
   input  logic rst_n,
   input  logic fault_raw,
   output logic level,
   output logic fault_evt
);

   localparam logic [31:0] DEB_LAST = DEBOUNCE_CYC - 1;

   logic        sync_1;
   logic        sync_2;
   logic [31:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         cnt       <= '0;
         level     <= 1'b0;
         fault_evt <= 1'b0;
      end else begin
         sync_1    <= fault_raw;
         sync_2    <= sync_1;
         fault_evt <= 1'b0;
         if (!sync_2) begin
            cnt   <= '0;
            level <= 1'b0;
         end else if (!level) begin
            // Counter freezes once the level is up, so a held sensor never retriggers.
            if (cnt == DEB_LAST) begin
               level     <= 1'b1;
               fault_evt <= 1'b1;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: rtl/fault_event_tracker.sv
// Turns raw bot events into held status levels for the LED driver and tracks one
// fault-service cycle (detect -> pick -> drop) tagged with the unit it occurred in.
module fault_event_tracker
   import astro_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 3125,
   parameter int unsigned PULSE_HOLD   = 312500
) (
   input  logic                  clk_3125KHz,
   input  logic                  rst_n,
   fault_event_tracker_if.slave  bus
);

   localparam logic [31:0] HOLD_LAST = PULSE_HOLD - 1;
   localparam logic [31:0] HOLD_LOAD = PULSE_HOLD;

   logic        fault_level;
   logic        fault_evt;
   state_t      state;
   state_t      next_state;
   logic [1:0]  unit_q;
   logic [31:0] drop_cnt;
   logic [31:0] node_cnt;
   logic        run_done;
   logic [1:0]  count_q;

   fault_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debouncer (
      .clk       (clk_3125KHz),
      .rst_n     (rst_n),
      .fault_raw (bus.fault_raw),
      .level     (fault_level),
      .fault_evt (fault_evt)
   );

   always_ff @(posedge clk_3125KHz) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Once the run has ended the FSM is parked in idle until reset.
   always_comb begin
      next_state = state;
      if (run_done || bus.run_end) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (fault_evt && (bus.unit_sel != UNIT_NONE)) next_state = S_FAULT;
            S_FAULT: if (bus.pick_done)                            next_state = S_CARRY;
            S_CARRY: if (bus.drop_done)                            next_state = S_DROP;
            S_DROP:  if (drop_cnt == HOLD_LAST)                    next_state = S_IDLE;
            default:                                               next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_3125KHz) begin
      if (!rst_n) begin
         unit_q   <= UNIT_EU;
         drop_cnt <= '0;
         node_cnt <= '0;
         run_done <= 1'b0;
         count_q  <= '0;
      end else begin
         if ((state == S_IDLE) && (next_state == S_FAULT)) unit_q <= bus.unit_sel;
         drop_cnt <= (state == S_DROP) ? drop_cnt + 32'd1 : '0;
         if ((state == S_CARRY) && (next_state == S_DROP) && (count_q != FAULT_COUNT_MAX))
            count_q <= count_q + 2'd1;
         if (bus.run_end) run_done <= 1'b1;
         // A retrigger reloads the full hold so the flag never dips between nodes.
         if (bus.node_reached)    node_cnt <= HOLD_LOAD;
         else if (node_cnt != '0) node_cnt <= node_cnt - 32'd1;
      end
   end

   always_comb begin
      bus.fault_detect  = (state == S_FAULT);
      bus.block_picked  = (state == S_CARRY);
      bus.object_drop   = (state == S_DROP);
      bus.EU_fault_flag = (state != S_IDLE) && (unit_q == UNIT_EU);
      bus.CU_fault_flag = (state != S_IDLE) && (unit_q == UNIT_CU);
      bus.RU_fault_flag = (state != S_IDLE) && (unit_q == UNIT_RU);
      bus.node_flag     = (node_cnt != '0);
      bus.run_complete  = run_done;
      bus.fault_count   = count_q;
      bus.fsm_state     = state;
      bus.fault_level   = fault_level;
   end

endmodule
